// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, control-word layout and function table for the nibble ALU
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, SBC = 4'd3,
        AND = 4'd4, XOR = 4'd5, OR  = 4'd6, CP  = 4'd7,
        CPL = 4'd8, INC = 4'd9, DEC = 4'd10
    } alu_cmd_t;

    typedef enum logic [1:0] {NO_LD = 2'd0, BUS_LD = 2'd1, ZERO_LD = 2'd2} alu_ld_t;
    typedef enum logic [1:0] {NO_SH = 2'd0, SH_L = 2'd1, SH_R = 2'd2} alu_sh_t;
    typedef enum logic [1:0] {NO_OE = 2'd0, SH_OE = 2'd1, RES_OE = 2'd2} alu_oe_t;

    typedef struct packed {
        logic r;
        logic s;
        logic v;
        logic ne;
    } alu_fn_t;

    typedef struct packed {
        logic [7:0] op;
        alu_sh_t    sh;
        alu_oe_t    oe;
        alu_ld_t    la;
        alu_ld_t    lb;
        logic       r;
        logic       s;
        logic       v;
        logic       ne;
        logic       ci;
        logic       l;
        logic       h;
    } alu_line_t;

    localparam alu_line_t ALU_NOP = '0;

    // r=AND, s=XOR, v=OR, otherwise add; ne inverts the B operand (subtract, CPL of a zeroed A)
    localparam alu_fn_t ALU_FN [16] = '{
        4'b0000, 4'b0000, 4'b0001, 4'b0001,
        4'b1000, 4'b0100, 4'b0010, 4'b0001,
        4'b0001, 4'b0000, 4'b0001, 4'b0000,
        4'b0000, 4'b0000, 4'b0000, 4'b0000
    };

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_seq_flags.sv
// rtl/alu_seq_flags.sv - SM83 flag values and write masks from the sampled ALU status
module alu_seq_flags
    import alu_pkg::*;
(
    input  alu_cmd_t   i_op,
    input  logic       i_h_raw,
    input  logic       i_zero,
    input  logic       i_carry,
    output logic [3:0] o_flags,
    output logic [3:0] o_mask
);

    // Subtractive ops see carry-out as "no borrow", so H and C are inverted
    always_comb begin
        o_flags = 4'b0000;
        o_mask  = 4'b0000;
        case (i_op)
            ADD, ADC: begin
                o_flags[FLAG_Z] = i_zero;
                o_flags[FLAG_H] = i_h_raw;
                o_flags[FLAG_C] = i_carry;
                o_mask          = 4'b1111;
            end
            SUB, SBC, CP: begin
                o_flags[FLAG_Z] = i_zero;
                o_flags[FLAG_N] = 1'b1;
                o_flags[FLAG_H] = ~i_h_raw;
                o_flags[FLAG_C] = ~i_carry;
                o_mask          = 4'b1111;
            end
            AND: begin
                o_flags[FLAG_Z] = i_zero;
                o_flags[FLAG_H] = 1'b1;
                o_mask          = 4'b1111;
            end
            XOR, OR: begin
                o_flags[FLAG_Z] = i_zero;
                o_mask          = 4'b1111;
            end
            CPL: begin
                o_flags[FLAG_N] = 1'b1;
                o_flags[FLAG_H] = 1'b1;
                o_mask          = 4'b0110;
            end
            INC: begin
                o_flags[FLAG_Z] = i_zero;
                o_flags[FLAG_H] = i_h_raw;
                o_mask          = 4'b1110;
            end
            DEC: begin
                o_flags[FLAG_Z] = i_zero;
                o_flags[FLAG_N] = 1'b1;
                o_flags[FLAG_H] = ~i_h_raw;
                o_mask          = 4'b1110;
            end
            default: begin
                o_flags = 4'b0000;
                o_mask  = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - expands ALU commands into per-cycle control words and registers the result
module alu_seq
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  alu_cmd_t   cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_cin,
    output alu_line_t  line,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_we,
    output logic [3:0] res_flags,
    output logic [3:0] res_flags_we
);

    typedef enum logic [2:0] {S_IDLE, S_LDB, S_LDA, S_LO, S_HI} state_t;

    state_t     r_state;
    state_t     w_next;
    alu_cmd_t   r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cin;
    logic       r_h_raw;
    logic       w_accept;
    logic       w_ci;
    alu_fn_t    w_fn;
    logic [3:0] w_flags;
    logic [3:0] w_mask;

    assign cmd_ready = (r_state == S_IDLE) || (r_state == S_HI);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_fn      = ALU_FN[r_op];

    always_comb begin
        w_ci = 1'b0;
        case (r_op)
            SUB, CP, DEC: w_ci = 1'b1;
            ADC:          w_ci = r_cin;
            SBC:          w_ci = ~r_cin;
            default:      w_ci = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        line   = ALU_NOP;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LDB;
            end
            S_LDB: begin
                w_next   = S_LDA;
                line.op  = (r_op == INC || r_op == DEC) ? 8'h01 : r_b;
                line.sh  = NO_SH;
                line.oe  = SH_OE;
                line.lb  = BUS_LD;
            end
            S_LDA: begin
                w_next   = S_LO;
                line.op  = r_a;
                line.la  = (r_op == CPL) ? ZERO_LD : BUS_LD;
            end
            S_LO: begin
                w_next   = S_HI;
                line.r   = w_fn.r;
                line.s   = w_fn.s;
                line.v   = w_fn.v;
                line.ne  = w_fn.ne;
                line.ci  = w_ci;
                line.l   = 1'b1;
            end
            S_HI: begin
                w_next   = w_accept ? S_LDB : S_IDLE;
                line.r   = w_fn.r;
                line.s   = w_fn.s;
                line.v   = w_fn.v;
                line.ne  = w_fn.ne;
                line.h   = 1'b1;
                line.oe  = RES_OE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_op  <= cmd_op;
            r_a   <= cmd_a;
            r_b   <= cmd_b;
            r_cin <= cmd_cin;
        end
        if (r_state == S_LO) begin
            r_h_raw <= alu_carry;
        end
    end

    alu_seq_flags u_flags (
        .i_op    (r_op),
        .i_h_raw (r_h_raw),
        .i_zero  (alu_zero),
        .i_carry (alu_carry),
        .o_flags (w_flags),
        .o_mask  (w_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_data     <= 8'h00;
            res_we       <= 1'b0;
            res_flags    <= 4'b0000;
            res_flags_we <= 4'b0000;
        end else begin
            res_valid <= (r_state == S_HI);
            if (r_state == S_HI) begin
                res_data     <= alu_result;
                res_we       <= (r_op != CP);
                res_flags    <= w_flags;
                res_flags_we <= w_mask;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a nibble-serial ALU stand-in
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    alu_cmd_t   cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_cin;
    alu_line_t  line;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_we;
    logic [3:0] res_flags;
    logic [3:0] res_flags_we;

    int n_vec  = 0;
    int n_miss = 0;

    alu_seq dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_cin      (cmd_cin),
        .line         (line),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_we       (res_we),
        .res_flags    (res_flags),
        .res_flags_we (res_flags_we)
    );

    always #5 clk = ~clk;

    // Nibble-serial ALU: operand latches, low nibble then high nibble with internal carry chain
    logic [7:0] alu_ra;
    logic [7:0] alu_rb;
    logic [3:0] alu_rlo;
    logic       alu_rcy;
    logic [4:0] nib_lo;
    logic [4:0] nib_hi;

    function automatic logic [4:0] nib(input logic [3:0] x, input logic [3:0] y, input logic c,
                                       input alu_line_t ln);
        logic [3:0] yb;
        yb = ln.ne ? ~y : y;
        if (ln.r) return {1'b0, x & yb};
        if (ln.s) return {1'b0, x ^ yb};
        if (ln.v) return {1'b0, x | yb};
        return {1'b0, x} + {1'b0, yb} + {4'b0000, c};
    endfunction

    always_comb begin
        nib_lo     = nib(alu_ra[3:0], alu_rb[3:0], line.ci, line);
        nib_hi     = nib(alu_ra[7:4], alu_rb[7:4], alu_rcy, line);
        alu_result = line.h ? {nib_hi[3:0], alu_rlo} : {4'h0, nib_lo[3:0]};
        alu_carry  = line.h ? nib_hi[4] : nib_lo[4];
        alu_zero   = (alu_result == 8'h00);
    end

    always @(posedge clk) begin
        if (line.lb == BUS_LD) alu_rb <= line.op;
        if (line.la == BUS_LD) alu_ra <= line.op;
        else if (line.la == ZERO_LD) alu_ra <= 8'h00;
        if (line.l) begin
            alu_rlo <= nib_lo[3:0];
            alu_rcy <= nib_lo[4];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference: plain 8-bit arithmetic with SM83 flag rules, flags as {Z,N,H,C}
    function automatic void ref_model(input alu_cmd_t op, input logic [7:0] a, input logic [7:0] b,
                                      input logic cin, output logic [7:0] r, output logic [3:0] f,
                                      output logic [3:0] m, output logic we);
        int ia, ib, ic, s;
        ia = int'(a);
        ib = int'(b);
        ic = int'(cin);
        we = (op != CP);
        m  = 4'b1111;
        f  = 4'b0000;
        r  = 8'h00;
        case (op)
            ADD, ADC: begin
                if (op == ADD) ic = 0;
                s = ia + ib + ic;
                r = s[7:0];
                f = {r == 8'h00, 1'b0, ((ia % 16) + (ib % 16) + ic) > 15, s > 255};
            end
            SUB, SBC, CP: begin
                if (op != SBC) ic = 0;
                s = ia - ib - ic;
                r = s[7:0];
                f = {r == 8'h00, 1'b1, (ia % 16) < ((ib % 16) + ic), ia < (ib + ic)};
            end
            AND: begin r = a & b; f = {r == 8'h00, 3'b010}; end
            XOR: begin r = a ^ b; f = {r == 8'h00, 3'b000}; end
            OR:  begin r = a | b; f = {r == 8'h00, 3'b000}; end
            CPL: begin r = ~b; f = 4'b0110; m = 4'b0110; end
            INC: begin r = a + 8'd1; f = {r == 8'h00, 1'b0, (ia % 16) == 15, 1'b0}; m = 4'b1110; end
            DEC: begin r = a - 8'd1; f = {r == 8'h00, 1'b1, (ia % 16) == 0, 1'b0}; m = 4'b1110; end
            default: m = 4'b0000;
        endcase
    endfunction

    // Offers a command at a negedge in IDLE; returns negedges from accept to res_valid (12 = timeout)
    task automatic do_cmd(input alu_cmd_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, output int lat);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        alu_cmd_t   op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [3:0] flg;
        logic [3:0] msk;
        logic       we;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int lat, gap, seen;
        logic [7:0] e_r;
        logic [3:0] e_f, e_m;
        logic e_we;
        alu_cmd_t rop;

        tbl[0]  = '{CPL, 8'h5A, 8'h35, 1'b0, 8'hCA, 4'b0110, 4'b0110, 1'b1};
        tbl[1]  = '{ADD, 8'h3A, 8'hC6, 1'b0, 8'h00, 4'b1011, 4'b1111, 1'b1};
        tbl[2]  = '{SBC, 8'h10, 8'h01, 1'b1, 8'h0E, 4'b0110, 4'b1111, 1'b1};
        tbl[3]  = '{CP,  8'h42, 8'h42, 1'b0, 8'h00, 4'b1100, 4'b1111, 1'b0};
        tbl[4]  = '{DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0110, 4'b1110, 1'b1};
        tbl[5]  = '{INC, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b1010, 4'b1110, 1'b1};
        tbl[6]  = '{AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0010, 4'b1111, 1'b1};
        tbl[7]  = '{XOR, 8'h55, 8'h55, 1'b0, 8'h00, 4'b1000, 4'b1111, 1'b1};
        tbl[8]  = '{OR,  8'h12, 8'h40, 1'b0, 8'h52, 4'b0000, 4'b1111, 1'b1};
        tbl[9]  = '{ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1011, 4'b1111, 1'b1};
        tbl[10] = '{SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0111, 4'b1111, 1'b1};
        tbl[11] = '{ADD, 8'h08, 8'h08, 1'b0, 8'h10, 4'b0010, 4'b1111, 1'b1};
        tbl[12] = '{INC, 8'h0F, 8'hAA, 1'b1, 8'h10, 4'b0010, 4'b1110, 1'b1};
        tbl[13] = '{SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0111, 4'b1111, 1'b1};
        tbl[14] = '{CP,  8'h10, 8'h20, 1'b0, 8'hF0, 4'b0101, 4'b1111, 1'b0};
        tbl[15] = '{ADC, 8'h0E, 8'h01, 1'b1, 8'h10, 4'b0010, 4'b1111, 1'b1};
        tbl[16] = '{DEC, 8'h10, 8'h99, 1'b0, 8'h0F, 4'b0110, 4'b1110, 1'b1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = ADD;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_cin   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_line", 32'(line), 32'(ALU_NOP));
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_we", 32'(res_we), 32'd0);
        chk("rst_flags", 32'(res_flags), 32'd0);
        chk("rst_mask", 32'(res_flags_we), 32'd0);

        // CPL: control-word walk and result timing
        cmd_valid = 1'b1; cmd_op = CPL; cmd_a = 8'h5A; cmd_b = 8'h35; cmd_cin = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ldb_op", 32'(line.op), 32'h35);
        chk("ldb_lb", 32'(line.lb), 32'(BUS_LD));
        chk("ldb_oe", 32'(line.oe), 32'(SH_OE));
        chk("ldb_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("lda_la", 32'(line.la), 32'(ZERO_LD));
        chk("lda_op", 32'(line.op), 32'h5A);
        @(negedge clk);
        chk("lo_lh", 32'({line.l, line.h}), 32'b10);
        @(negedge clk);
        chk("hi_lh", 32'({line.l, line.h}), 32'b01);
        chk("hi_ci", 32'(line.ci), 32'd0);
        chk("hi_oe", 32'(line.oe), 32'(RES_OE));
        chk("hi_ready", 32'(cmd_ready), 32'd1);
        chk("hi_novalid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("cpl_valid", 32'(res_valid), 32'd1);
        chk("cpl_data", 32'(res_data), 32'hCA);
        chk("cpl_mask", 32'(res_flags_we), 32'b0110);
        chk("cpl_flags", 32'(res_flags & res_flags_we), 32'b0110);
        @(negedge clk);
        chk("cpl_pulse", 32'(res_valid), 32'd0);
        chk("cpl_hold", 32'(res_data), 32'hCA);

        // SBC: LO carry-in is ~cin
        cmd_valid = 1'b1; cmd_op = SBC; cmd_a = 8'h10; cmd_b = 8'h01; cmd_cin = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sbc_lo_ci", 32'(line.ci), 32'd0);
        repeat (2) @(negedge clk);
        chk("sbc_valid", 32'(res_valid), 32'd1);
        chk("sbc_data", 32'(res_data), 32'h0E);

        // DEC then INC accepted in HI
        cmd_valid = 1'b1; cmd_op = DEC; cmd_a = 8'h00; cmd_b = 8'h77; cmd_cin = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_ready_hi", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = INC; cmd_a = 8'h41; cmd_b = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("dec_valid", 32'(res_valid), 32'd1);
        chk("dec_data", 32'(res_data), 32'hFF);
        chk("dec_mask", 32'(res_flags_we), 32'b1110);
        chk("dec_flags", 32'(res_flags & res_flags_we), 32'b0110);
        gap = 0;
        while (gap < 10) begin
            @(negedge clk);
            gap++;
            if (res_valid) break;
        end
        chk("b2b_gap", 32'(gap), 32'd4);
        chk("inc_data", 32'(res_data), 32'h42);
        chk("inc_flags", 32'(res_flags & res_flags_we), 32'b0000);
        @(negedge clk);

        // Reset while in LO drops the command
        cmd_valid = 1'b1; cmd_op = ADD; cmd_a = 8'h3A; cmd_b = 8'hC6; cmd_cin = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_lo", 32'(line.l), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_line", 32'(line), 32'(ALU_NOP));
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_data", 32'(res_data), 32'd0);
        chk("mid_rst_mask", 32'(res_flags_we), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        chk("mid_rst_dropped", 32'(seen), 32'd0);

        for (int i = 0; i < 17; i++) begin
            do_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd5);
            chk($sformatf("tbl%0d_data", i), 32'(res_data), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_flags", i), 32'(res_flags & res_flags_we), 32'(tbl[i].flg));
            chk($sformatf("tbl%0d_mask", i), 32'(res_flags_we), 32'(tbl[i].msk));
            chk($sformatf("tbl%0d_we", i), 32'(res_we), 32'(tbl[i].we));
            @(negedge clk);
        end

        for (int i = 0; i < 200; i++) begin
            rop   = alu_cmd_t'($urandom_range(0, 10));
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            cmd_cin = 1'($urandom);
            ref_model(rop, cmd_a, cmd_b, cmd_cin, e_r, e_f, e_m, e_we);
            do_cmd(rop, cmd_a, cmd_b, cmd_cin, lat);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd5);
            chk($sformatf("rnd%0d_data op%0d", i, rop), 32'(res_data), 32'(e_r));
            chk($sformatf("rnd%0d_flags op%0d", i, rop), 32'(res_flags & res_flags_we), 32'(e_f & e_m));
            chk($sformatf("rnd%0d_mask", i), 32'(res_flags_we), 32'(e_m));
            chk($sformatf("rnd%0d_we", i), 32'(res_we), 32'(e_we));
            if (($urandom & 1) == 1) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Micro-sequencer directly upstream of the nibble-serial ALU. Accepts one 8-bit ALU command per handshake, expands it into the ALU's per-cycle control words (operand-load cycles, low-nibble cycle, high-nibble cycle), and samples the ALU's `result`/`zero`/`carry` outputs. Produces a registered 8-bit result plus SM83 Z/N/H/C flag values and write masks for the register file and flag register.

## Interface
- No parameters.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high.
- `cmd_valid  in  1`: command offered.
- `cmd_ready  out  1`: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op  in  4`: `alu_cmd_t`: ADD, ADC, SUB, SBC, AND, XOR, OR, CP, CPL, INC, DEC.
- `cmd_a  in  8`: accumulator operand.
- `cmd_b  in  8`: second operand. Ignored for INC/DEC.
- `cmd_cin  in  1`: current C flag. Used by ADC/SBC only.
- `line  out  alu_line_t`: ALU control word for this cycle (fields `op, sh, oe, la, lb, r, s, v, ne, ci, l, h`).
- `alu_result  in  8`, `alu_zero  in  1`, `alu_carry  in  1`: ALU outputs, valid combinationally in the cycle of the corresponding control word.
- `res_valid  out  1`: one-cycle pulse.
- `res_data  out  8`: result.
- `res_we  out  1`: write `res_data` to A. 0 for CP.
- `res_flags  out  4`: {Z,N,H,C}.
- `res_flags_we  out  4`: per-flag write mask.

## Operation
- States: IDLE, LDB, LDA, LO, HI.
- `cmd_ready` = 1 in IDLE and HI. An accept latches op/a/b/cin and moves to LDB. Otherwise IDLE→IDLE and HI→IDLE.
- Fixed transitions: LDB→LDA→LO→HI.
- Control word per state:
  - IDLE: `ALU_NOP`: `la=lb=NO_LD`, `oe` none, `l=h=0`.
  - LDB: `op=B'`, `sh=NO_SH`, `oe=SH_OE`, `lb=BUS_LD`. `B'` = 8'h01 for INC/DEC, else latched b.
  - LDA: `op=a`, `la=BUS_LD`. For CPL only, `la=ZERO_LD`.
  - LO: `l=1`, `h=0`, function fields `r,s,v,ne` from `ALU_FN[op]`. `ci` is 1 for SUB/CP/DEC, cin for ADC, ~cin for SBC, else 0.
  - HI: same function fields, `l=0`, `h=1`, `ci=0` (ALU chains nibble carry internally), `oe=RES_OE`.
- Sampling: `alu_carry` in LO → half-carry `h_raw`. `alu_result`, `alu_zero`, `alu_carry` in HI → registered outputs.
- Flags (SM83 semantics; subtractive carry/half-carry = ~borrow-out inverted to borrow):
  - ADD/ADC: Z=zero, N=0, H=h_raw, C=carry. Mask 1111.
  - SUB/SBC/CP: Z=zero, N=1, H=~h_raw, C=~carry. Mask 1111.
  - AND: Z, N=0, H=1, C=0. Mask 1111.
  - XOR/OR: Z, N=0, H=0, C=0. Mask 1111.
  - CPL: N=1, H=1. Mask 0110.
  - INC: Z, N=0, H=h_raw. Mask 1110.
  - DEC: Z, N=1, H=~h_raw. Mask 1110.
- Widths: all 8-bit arithmetic wraps mod 256. Zero reflects the 8-bit result only.
- Reset (any state, including mid-command): state←IDLE, `line=ALU_NOP`, `res_valid=0`, `res_data=0`, `res_flags=0`, masks=0, `res_we=0`. An in-flight command is dropped with no result.

## Timing
- Accept at cycle T: LDB at T+1, LDA at T+2, LO at T+3, HI at T+4, `res_valid` at T+5.
- Latency is 5 cycles. Back-to-back throughput is one command per 4 cycles: accept in HI at T+4 puts LDB at T+5, concurrently with the previous `res_valid`.
- `res_*` outputs hold their values until the next `res_valid`. `res_valid` is never held for more than one cycle. There is no output backpressure.

## Structure
- Shared package `alu_pkg` holds: `alu_line_t`, `alu_cmd_t`, load/output/shift enums (`NO_LD`, `BUS_LD`, `ZERO_LD`, `NO_SH`, `SH_OE`, `RES_OE`), `ALU_NOP`, `ALU_FN[]` (per-op r/s/v/ne), and flag bit indices.
- One sub-module, `alu_seq_flags`: combinational flag and mask computation from op, `h_raw`, zero and carry.

## Test plan
- CPL, b=8'h35 → `line` LDB `op=35`, LDA `la=ZERO_LD`. `res_data=CA`, flags N=1,H=1, mask 0110, `res_valid` at T+5.
- ADD a=3A, b=C6 → `res_data=00`, Z=1, N=0, H=1, C=1, mask 1111.
- SBC a=10, b=01, cin=1 → LO `ci=0`. `res_data=0E`, N=1, H=1, C=0.
- CP a=42, b=42 → `res_we=0`, Z=1, N=1, C=0.
- DEC a=00 → `res_data=FF`, H=1, mask 1110. Back-to-back INC accepted in HI → second `res_valid` exactly 4 cycles after the first.
- Reset asserted in LO → next cycle IDLE, `line=ALU_NOP`, no `res_valid`, `cmd_ready=1`.
